// File: rtl/fpu_addsub_sequencer_if.sv
// ---------------------------------------------------------------------------
// fpu_addsub_sequencer_if
// Bundles the handshake, operand, datapath-status and flag signals that pass
// between the issue logic and the add/sub sequencer.
//   master : issue/datapath side. Drives requests, operands, MantCmp,
//            NormDone, ResultReady and Flush. Receives enables and flags.
//   slave  : sequencer side. Mirror of master.
// ---------------------------------------------------------------------------
interface fpu_addsub_sequencer_if #(
    parameter int EXP_W = 8
);
    // request / handshake
    logic             StartValid;
    logic             StartReady;
    logic             OpSub;
    logic             SignX;
    logic             SignY;
    logic [EXP_W-1:0] ExpX;
    logic [EXP_W-1:0] ExpY;
    // datapath status
    logic             MantCmp;
    logic             NormDone;
    logic             ResultReady;
    logic             Flush;
    // stage enables
    logic             LoadEn;
    logic             AlignEn;
    logic             AddEn;
    logic             NormEn;
    // registered operand-relation flags
    logic             SwapOps;
    logic             EffOperation;
    logic             ExclusiveSign;
    logic             DSign;
    logic             DZF;
    logic             CMP1;
    logic             ResultValid;
    logic             NormTimeout;

    modport master (
        output StartValid, OpSub, SignX, SignY, ExpX, ExpY,
               MantCmp, NormDone, ResultReady, Flush,
        input  StartReady, LoadEn, AlignEn, AddEn, NormEn,
               SwapOps, EffOperation, ExclusiveSign, DSign, DZF, CMP1,
               ResultValid, NormTimeout
    );

    modport slave (
        input  StartValid, OpSub, SignX, SignY, ExpX, ExpY,
               MantCmp, NormDone, ResultReady, Flush,
        output StartReady, LoadEn, AlignEn, AddEn, NormEn,
               SwapOps, EffOperation, ExclusiveSign, DSign, DZF, CMP1,
               ResultValid, NormTimeout
    );
endinterface

// File: rtl/fpu_addsub_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_addsub_sequencer
// Multi-cycle controller for the floating-point add/sub datapath. It accepts
// one operation through StartValid/StartReady and registers the operand
// relation flags for the sign stage. It then walks the datapath through
// LOAD -> ALIGN (serial, one shift per cycle) -> ADD -> NORM -> DONE using
// one-hot stage enables.
// Ports:
//   Clk  : clock, rising edge
//   Rst  : synchronous active-high reset, has priority over Flush
//   bus  : slave side of fpu_addsub_sequencer_if (handshake, operands,
//          datapath status, stage enables, flags, result handshake)
// ---------------------------------------------------------------------------
module fpu_addsub_sequencer #(
    parameter int EXP_W     = 8,
    parameter int MAX_SHIFT = 26,
    parameter int NORM_MAX  = 27
) (
    input  logic                    Clk,
    input  logic                    Rst,
    fpu_addsub_sequencer_if.slave   bus
);
    localparam int AW = $clog2(MAX_SHIFT + 1);
    localparam int NW = $clog2(NORM_MAX);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ALIGN,
        ST_ADD,
        ST_NORM,
        ST_DONE
    } state_t;

    state_t          r_state, w_state_next;
    logic [AW-1:0]   r_align_cnt, w_align_cnt_next;
    logic [NW-1:0]   r_norm_cnt, w_norm_cnt_next;
    logic            r_swap, w_swap_next;
    logic            r_eff_op, w_eff_op_next;
    logic            r_excl_sign, w_excl_sign_next;
    logic            r_dsign, w_dsign_next;
    logic            r_dzf, w_dzf_next;
    logic            r_cmp1, w_cmp1_next;
    logic            r_norm_tmo, w_norm_tmo_next;

    // Exponent difference one bit wider than the exponents, so it never wraps.
    logic             w_x_ge_y;
    logic [EXP_W:0]   w_diff;
    logic [EXP_W:0]   w_diff_sat;

    assign w_x_ge_y   = (bus.ExpX >= bus.ExpY);
    assign w_diff     = w_x_ge_y ? ({1'b0, bus.ExpX} - {1'b0, bus.ExpY})
                                 : ({1'b0, bus.ExpY} - {1'b0, bus.ExpX});
    assign w_diff_sat = (w_diff > (EXP_W+1)'(MAX_SHIFT)) ? (EXP_W+1)'(MAX_SHIFT)
                                                         : w_diff;

    always_comb begin
        w_state_next     = r_state;
        w_align_cnt_next = r_align_cnt;
        w_norm_cnt_next  = r_norm_cnt;
        w_swap_next      = r_swap;
        w_eff_op_next    = r_eff_op;
        w_excl_sign_next = r_excl_sign;
        w_dsign_next     = r_dsign;
        w_dzf_next       = r_dzf;
        w_cmp1_next      = r_cmp1;
        w_norm_tmo_next  = r_norm_tmo;

        // Flush abandons the op without touching any flag or counter.
        if (bus.Flush && (r_state != ST_IDLE)) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.StartValid) begin
                        w_excl_sign_next = bus.SignX ^ bus.SignY;
                        w_eff_op_next    = bus.OpSub ^ bus.SignX ^ bus.SignY;
                        w_dsign_next     = w_x_ge_y;
                        w_dzf_next       = (bus.ExpX == bus.ExpY);
                        w_swap_next      = ~w_x_ge_y;
                        w_align_cnt_next = AW'(w_diff_sat);
                        w_norm_tmo_next  = 1'b0;
                        w_state_next     = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    w_state_next = (r_align_cnt != '0) ? ST_ALIGN : ST_ADD;
                end
                ST_ALIGN: begin
                    // Leaving on count==1 yields exactly AlignCnt shift cycles.
                    w_align_cnt_next = r_align_cnt - 1'b1;
                    if (r_align_cnt == AW'(1)) begin
                        w_state_next = ST_ADD;
                    end
                end
                ST_ADD: begin
                    w_cmp1_next     = bus.MantCmp;
                    w_norm_cnt_next = '0;
                    w_state_next    = ST_NORM;
                end
                ST_NORM: begin
                    if (bus.NormDone) begin
                        w_state_next = ST_DONE;
                    end else if (r_norm_cnt == NW'(NORM_MAX - 1)) begin
                        w_norm_tmo_next = 1'b1;
                        w_state_next    = ST_DONE;
                    end else begin
                        w_norm_cnt_next = r_norm_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (bus.ResultReady) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state     <= ST_IDLE;
            r_align_cnt <= '0;
            r_norm_cnt  <= '0;
            r_swap      <= 1'b0;
            r_eff_op    <= 1'b0;
            r_excl_sign <= 1'b0;
            r_dsign     <= 1'b0;
            r_dzf       <= 1'b0;
            r_cmp1      <= 1'b0;
            r_norm_tmo  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_align_cnt <= w_align_cnt_next;
            r_norm_cnt  <= w_norm_cnt_next;
            r_swap      <= w_swap_next;
            r_eff_op    <= w_eff_op_next;
            r_excl_sign <= w_excl_sign_next;
            r_dsign     <= w_dsign_next;
            r_dzf       <= w_dzf_next;
            r_cmp1      <= w_cmp1_next;
            r_norm_tmo  <= w_norm_tmo_next;
        end
    end

    // Enables decode the registered state only, so no input reaches them
    // combinationally.
    assign bus.StartReady    = (r_state == ST_IDLE);
    assign bus.LoadEn        = (r_state == ST_LOAD);
    assign bus.AlignEn       = (r_state == ST_ALIGN);
    assign bus.AddEn         = (r_state == ST_ADD);
    assign bus.NormEn        = (r_state == ST_NORM);
    assign bus.ResultValid   = (r_state == ST_DONE);
    assign bus.SwapOps       = r_swap;
    assign bus.EffOperation  = r_eff_op;
    assign bus.ExclusiveSign = r_excl_sign;
    assign bus.DSign         = r_dsign;
    assign bus.DZF           = r_dzf;
    assign bus.CMP1          = r_cmp1;
    assign bus.NormTimeout   = r_norm_tmo;

endmodule

// File: doc/fpu_addsub_sequencer.md
# fpu_addsub_sequencer

Multi-cycle controller for the floating-point add/sub datapath. It accepts one operation at a time through a valid/ready handshake and derives and registers the operand-relation flags consumed by the sign stage (effective operation, exclusive sign, exponent-difference sign and zero flag, mantissa compare). It then steps the datapath through load, serial alignment, add, normalise and result hand-off, driving one-hot stage enables. It sits between the issue logic and the add/sub datapath, and its flag outputs feed the sign stage directly.

## Interface
- EXP_W, 8, exponent width
- MAX_SHIFT, 26, alignment shift saturation (mantissa + guard/round/sticky)
- NORM_MAX, 27, maximum normalise cycles before forced exit
- Clk  input  1  clock; all state changes on rising edge
- Rst  input  1  reset, synchronous, active-high
- StartValid  input  1  operation request
- StartReady  output  1  sequencer can accept (state IDLE)
- OpSub  input  1  requested op: 0 add, 1 subtract
- SignX, SignY  input  1 each  operand signs
- ExpX, ExpY  input  EXP_W each  biased exponents
- MantCmp  input  1  datapath compare, 1 = My > Mx
- NormDone  input  1  normaliser reports leading one in place
- ResultReady  input  1  downstream accepts result
- Flush  input  1  abort current operation
- LoadEn, AlignEn, AddEn, NormEn  output  1 each  stage enables, at most one high per cycle
- SwapOps  output  1  registered: 1 = Ey > Ex; datapath shifts X instead of Y
- EffOperation  output  1  registered: 1 = effective subtract
- ExclusiveSign  output  1  registered SignX ^ SignY
- DSign  output  1  registered: 1 = Ex >= Ey
- DZF  output  1  registered: Ex == Ey
- CMP1  output  1  registered MantCmp
- ResultValid  output  1  result and flags valid
- NormTimeout  output  1  sticky for the current op: NORM exited on NORM_MAX

## Operation
- States: IDLE, LOAD, ALIGN, ADD, NORM, DONE.
- IDLE: StartReady=1. On StartValid, capture the following:
  - ExclusiveSign = SignX ^ SignY.
  - EffOperation = OpSub ^ SignX ^ SignY.
  - DSign = (ExpX >= ExpY); DZF = (ExpX == ExpY); SwapOps = ~DSign.
  - AlignCnt = min(|ExpX − ExpY|, MAX_SHIFT). Compute the difference at EXP_W+1 bits, no wrap.
  - Clear NormTimeout. Go to LOAD.
- LOAD: LoadEn=1 for one cycle. Go to ALIGN if AlignCnt≠0, else ADD.
- ALIGN: AlignEn=1 and AlignCnt decrements each cycle. Leave for ADD in the cycle AlignCnt reaches 1, giving exactly AlignCnt AlignEn cycles.
- ADD: AddEn=1 for one cycle; CMP1 ← MantCmp. CMP1 is meaningful only when DZF=1 and is captured regardless. Go to NORM.
- NORM: NormEn=1 and NormCnt increments from 0.
  - Exit to DONE when NormDone=1.
  - Also exit to DONE when NormCnt reaches NORM_MAX−1; set NormTimeout=1 if NormDone is still 0.
- DONE: ResultValid=1. All flags held stable. On ResultReady go to IDLE.
- Flush (any state except IDLE): next state IDLE with all enables and ResultValid cleared; flags keep their last values.
- Rst has priority over Flush, and Flush over all transitions.
- Reset values: state IDLE, all enables 0, ResultValid 0, StartReady 1. All flags, SwapOps, NormTimeout and both counters 0.

## Timing
- Handshake: transfer when StartValid & StartReady are high at a rising edge. No second accept until the sequencer returns to IDLE.
- Operand inputs are sampled only on the accept edge. Changes afterwards are ignored.
- Latency from accept edge to ResultValid = 3 + AlignCnt + NormCycles (NormCycles ≥ 1).
- Minimum latency is 4 (AlignCnt=0, NormDone in the first NORM cycle).
- DONE→IDLE costs one cycle: peak throughput is one op per (latency + 1) cycles.
- ResultValid is held while ResultReady=0 for unbounded time.
- Stage enables and ResultValid are registered (state-decoded from registered state); no combinational path from inputs to enables.
- StartReady is combinational on state only.
- MantCmp is sampled only in ADD; NormDone only in NORM.

## Test plan
- Add 1.5+1.0 with ExpX=ExpY=127, SignX=SignY=0, OpSub=0, NormDone=1 in the first NORM cycle:
  - ResultValid 4 cycles after accept.
  - EffOperation=0, ExclusiveSign=0, DSign=1, DZF=1, AlignEn never high.
- ExpX=130, ExpY=127, OpSub=1, signs 0/0: AlignEn high exactly 3 cycles, EffOperation=1, DSign=1, DZF=0, SwapOps=0, latency 7.
- ExpX=10, ExpY=200 (diff 190 > MAX_SHIFT):
  - AlignEn high exactly 26 cycles, DSign=0, SwapOps=1.
  - OpSub=0 with SignX≠SignY gives EffOperation=1.
- ExpX=ExpY, MantCmp=1 during ADD, NormDone held 0:
  - CMP1=1.
  - NormEn high 27 cycles, then DONE with NormTimeout=1.
- ResultReady held 0 for 10 cycles in DONE:
  - ResultValid and flags stable, StartValid ignored.
  - Once ResultReady=1: IDLE next cycle, StartReady=1.
- Flush asserted during ALIGN (cycle 2 of 5), and separately Rst asserted together with Flush:
  - IDLE on the next edge, all enables 0, no ResultValid.
  - In the Rst+Flush case all flags are 0.
